remote_load_resp: RTL
=====================

Name: remote_load_resp

Overview:
- Receive-side counterpart of the tile's remote request path.
- Accepts remote load and icache-fetch responses returned from the network RX endpoint and buffers them in a small FIFO.
- Uses the returned load_info to extract bytes and halfwords, then sign- or zero-extends them.
- Steers each response to the integer-RF writeback, FP-RF writeback or icache refill port; also tracks outstanding remote loads for issue gating.

Parameters:
- data_width_p, 32, response data width (fixed at 32 for extraction logic).
- reg_addr_width_p, 5, register id width.
- fifo_els_p, 4, response FIFO depth (power of 2, >=2).
- max_out_p, 16, maximum outstanding remote loads/fetches.

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  reset; synchronous, active-low
- resp_v_i  in  1  response valid from RX
- resp_data_i  in  data_width_p  returned 32-bit word
- resp_reg_id_i  in  reg_addr_width_p  destination register
- resp_load_info_i  in  7  {float_wb, icache_fetch, is_unsigned_op, is_byte_op, is_hex_op, part_sel[1:0]}
- resp_ready_o  out  1  FIFO can accept
- issue_v_i  in  1  one remote load or icache fetch issued this cycle
- outstanding_o  out  clog2(max_out_p+1)  in-flight count
- credit_avail_o  out  1  outstanding_o < max_out_p
- int_wb_v_o / int_wb_reg_id_o / int_wb_data_o  out  1 / reg_addr_width_p / data_width_p  integer writeback
- int_wb_yumi_i  in  1  integer writeback consumed
- fp_wb_v_o / fp_wb_reg_id_o / fp_wb_data_o  out  1 / reg_addr_width_p / data_width_p  FP writeback
- fp_wb_yumi_i  in  1
- icache_v_o / icache_data_o  out  1 / data_width_p  icache refill word
- icache_yumi_i  in  1

Behaviour:
- Reset (reset_n_i=0 at posedge): FIFO empty, pointers 0, outstanding_o=0. While held: resp_ready_o=0, credit_avail_o=1, all *_v_o=0, data outputs 0. Reset mid-operation discards all buffered entries.
- Enqueue: resp_v_i & resp_ready_o. resp_ready_o = ~full only, with no combinational dependence on yumi. At full with a simultaneous dequeue, the incoming beat is not accepted.
- FIFO: circular, fifo_els_p entries, extra wrap bit on the read and write pointers. Empty when pointers are equal; full when indices are equal and wrap bits differ.
- Head steering, evaluated when the FIFO is non-empty; exactly one valid is asserted:
  - icache_fetch=1 → icache_v_o.
  - else float_wb=1 → fp_wb_v_o.
  - else → int_wb_v_o.
- Dequeue: the yumi of the active port. A yumi on an inactive port is ignored and triggers an assertion error in simulation.
- Data extraction:
  - icache and FP responses: raw word.
  - int with is_byte_op: byte = data[8*part_sel +: 8]; zero-extended if is_unsigned_op, else sign-extended from bit 7.
  - int with is_hex_op: half = data[16*part_sel[1] +: 16]; extended likewise from bit 15.
  - otherwise: raw word.
- Latency (macro off): a response accepted at edge N is visible on its output port after edge N; one entry may drain per cycle.
- Outstanding counter:
  - +1 on issue_v_i; −1 on enqueue; both in the same cycle → unchanged.
  - Underflow (enqueue at 0) and overflow (issue at max_out_p) are simulation assertion errors; the counter holds in either case.

Optional Feature:
- Macro REMOTE_LOAD_RESP_BYPASS_EN.
- Defined: when the FIFO is empty and resp_v_i=1, the incoming response is steered and extracted combinationally onto its output in the same cycle. If the matching yumi is asserted that cycle, the entry is not written to the FIFO, though it still decrements the counter. resp_ready_o is unchanged.
- Undefined: minimum one-cycle latency through the FIFO.

Test Plan:
- Reset then signed byte load: data=0x80FF_7F01, byte, part_sel=3, signed, reg 5 → int_wb_v_o=1, reg 5, data 0xFFFF_FF80; unsigned variant → 0x0000_0080.
- Halfword: data=0x8001_1234, hex, part_sel=2'b10, signed → 0xFFFF_8001; part_sel=2'b00 → 0x0000_1234.
- Routing: float_wb=1 data 0x3F80_0000 → fp_wb only, raw word. icache_fetch=1 (float_wb=1 also set) → icache_v_o only.
- Backpressure: 4 responses, no yumi → resp_ready_o=0 after 4th. 5th held off. Yumi one → ready=1 next cycle. Data returned in FIFO order, including across pointer wrap after 6 total.
- Credits: 16 issue_v_i pulses → outstanding_o=16, credit_avail_o=0. Simultaneous issue+enqueue → stays 16. Enqueue → 15, credit_avail_o=1.
- Reset mid-stream with 3 buffered entries → next cycle all *_v_o=0, outstanding_o=0. With REMOTE_LOAD_RESP_BYPASS_EN: an empty-FIFO response with same-cycle yumi completes in 0 cycles and the FIFO stays empty.

Source files
------------

// File: rtl/remote_load_resp_if.sv
// Bundles the RX response, issue tracking and writeback/refill ports of remote_load_resp.
// slave is the block's own view; master is the surrounding tile (or a bench).
interface remote_load_resp_if #(
  parameter int data_width_p     = 32,
  parameter int reg_addr_width_p = 5,
  parameter int max_out_p        = 16
);
  localparam int out_width_lp = $clog2(max_out_p + 1);

  logic                        resp_v_i;
  logic [data_width_p-1:0]     resp_data_i;
  logic [reg_addr_width_p-1:0] resp_reg_id_i;
  logic [6:0]                  resp_load_info_i;
  logic                        resp_ready_o;

  logic                        issue_v_i;
  logic [out_width_lp-1:0]     outstanding_o;
  logic                        credit_avail_o;

  logic                        int_wb_v_o;
  logic [reg_addr_width_p-1:0] int_wb_reg_id_o;
  logic [data_width_p-1:0]     int_wb_data_o;
  logic                        int_wb_yumi_i;

  logic                        fp_wb_v_o;
  logic [reg_addr_width_p-1:0] fp_wb_reg_id_o;
  logic [data_width_p-1:0]     fp_wb_data_o;
  logic                        fp_wb_yumi_i;

  logic                        icache_v_o;
  logic [data_width_p-1:0]     icache_data_o;
  logic                        icache_yumi_i;

  modport slave (
    input  resp_v_i, resp_data_i, resp_reg_id_i, resp_load_info_i, issue_v_i,
           int_wb_yumi_i, fp_wb_yumi_i, icache_yumi_i,
    output resp_ready_o, outstanding_o, credit_avail_o,
           int_wb_v_o, int_wb_reg_id_o, int_wb_data_o,
           fp_wb_v_o, fp_wb_reg_id_o, fp_wb_data_o,
           icache_v_o, icache_data_o
  );

  modport master (
    output resp_v_i, resp_data_i, resp_reg_id_i, resp_load_info_i, issue_v_i,
           int_wb_yumi_i, fp_wb_yumi_i, icache_yumi_i,
    input  resp_ready_o, outstanding_o, credit_avail_o,
           int_wb_v_o, int_wb_reg_id_o, int_wb_data_o,
           fp_wb_v_o, fp_wb_reg_id_o, fp_wb_data_o,
           icache_v_o, icache_data_o
  );
endinterface

// File: rtl/remote_load_resp.sv
// Buffers remote load / icache-fetch responses, extracts sub-words and steers them to their consumer.
// Optional macro REMOTE_LOAD_RESP_BYPASS_EN lets a response reaching an empty FIFO appear in the same cycle.
module remote_load_resp #(
  parameter int data_width_p     = 32,
  parameter int reg_addr_width_p = 5,
  parameter int fifo_els_p       = 4,
  parameter int max_out_p        = 16
) (
  input logic                clk_i,
  input logic                reset_n_i,
  remote_load_resp_if.slave  io
);
  localparam int ptr_w_lp = $clog2(fifo_els_p);
  localparam int cnt_w_lp = $clog2(max_out_p + 1);
  localparam logic [cnt_w_lp-1:0] max_cnt_lp = cnt_w_lp'(max_out_p);

  logic [data_width_p-1:0]     data_mem [fifo_els_p];
  logic [reg_addr_width_p-1:0] reg_mem  [fifo_els_p];
  logic [6:0]                  info_mem [fifo_els_p];

  logic [ptr_w_lp:0]           wr_ptr, rd_ptr;
  logic [cnt_w_lp-1:0]         out_cnt;

  logic                        empty, full, ready, enq, bypass_v, head_v;
  logic                        yumi_act, fifo_wr, fifo_rd;
  logic [data_width_p-1:0]     sel_data;
  logic [reg_addr_width_p-1:0] sel_reg;
  logic [6:0]                  sel_info;

  // load_info = {float_wb, icache_fetch, is_unsigned_op, is_byte_op, is_hex_op, part_sel[1:0]}
  function automatic logic [31:0] extract_data(input logic [31:0] d, input logic [6:0] info);
    logic [7:0]  b;
    logic [15:0] h;
    logic        sgn;
    case (info[1:0])
      2'd0:    b = d[7:0];
      2'd1:    b = d[15:8];
      2'd2:    b = d[23:16];
      default: b = d[31:24];
    endcase
    h   = info[1] ? d[31:16] : d[15:0];
    sgn = ~info[4];
    if (info[5] | info[6])
      return d;
    else if (info[3])
      return {{24{sgn & b[7]}}, b};
    else if (info[2])
      return {{16{sgn & h[15]}}, h};
    else
      return d;
  endfunction

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[ptr_w_lp-1:0] == rd_ptr[ptr_w_lp-1:0]) &&
                   (wr_ptr[ptr_w_lp] != rd_ptr[ptr_w_lp]);
  assign ready   = reset_n_i & ~full;
  assign enq     = io.resp_v_i & ready;

`ifdef REMOTE_LOAD_RESP_BYPASS_EN
  assign bypass_v = reset_n_i & empty & io.resp_v_i;
`else
  assign bypass_v = 1'b0;
`endif

  assign head_v  = reset_n_i & (~empty | bypass_v);

  assign io.resp_ready_o   = ready;
  assign io.outstanding_o  = reset_n_i ? out_cnt : '0;
  assign io.credit_avail_o = ~reset_n_i | (out_cnt < max_cnt_lp);

  // Head source is the FIFO, or the live input when bypassing an empty FIFO
  always_comb begin
    sel_data = data_mem[rd_ptr[ptr_w_lp-1:0]];
    sel_reg  = reg_mem[rd_ptr[ptr_w_lp-1:0]];
    sel_info = info_mem[rd_ptr[ptr_w_lp-1:0]];
    if (bypass_v) begin
      sel_data = io.resp_data_i;
      sel_reg  = io.resp_reg_id_i;
      sel_info = io.resp_load_info_i;
    end
  end

  always_comb begin
    io.int_wb_v_o      = 1'b0;
    io.int_wb_reg_id_o = '0;
    io.int_wb_data_o   = '0;
    io.fp_wb_v_o       = 1'b0;
    io.fp_wb_reg_id_o  = '0;
    io.fp_wb_data_o    = '0;
    io.icache_v_o      = 1'b0;
    io.icache_data_o   = '0;
    if (head_v) begin
      if (sel_info[5]) begin
        io.icache_v_o    = 1'b1;
        io.icache_data_o = sel_data;
      end else if (sel_info[6]) begin
        io.fp_wb_v_o      = 1'b1;
        io.fp_wb_reg_id_o = sel_reg;
        io.fp_wb_data_o   = sel_data;
      end else begin
        io.int_wb_v_o      = 1'b1;
        io.int_wb_reg_id_o = sel_reg;
        io.int_wb_data_o   = extract_data(sel_data, sel_info);
      end
    end
  end

  assign yumi_act = (io.icache_v_o & io.icache_yumi_i) |
                    (io.fp_wb_v_o  & io.fp_wb_yumi_i)  |
                    (io.int_wb_v_o & io.int_wb_yumi_i);
  assign fifo_rd  = yumi_act & ~empty;
  assign fifo_wr  = enq & ~(bypass_v & yumi_act);

  always_ff @(posedge clk_i) begin
    if (fifo_wr) begin
      data_mem[wr_ptr[ptr_w_lp-1:0]] <= io.resp_data_i;
      reg_mem[wr_ptr[ptr_w_lp-1:0]]  <= io.resp_reg_id_i;
      info_mem[wr_ptr[ptr_w_lp-1:0]] <= io.resp_load_info_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (fifo_wr) wr_ptr <= wr_ptr + 1'b1;
      if (fifo_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Counter holds rather than wrapping on underflow/overflow
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      out_cnt <= '0;
    end else if (io.issue_v_i && !enq) begin
      if (out_cnt != max_cnt_lp) out_cnt <= out_cnt + 1'b1;
    end else if (!io.issue_v_i && enq) begin
      if (out_cnt != '0) out_cnt <= out_cnt - 1'b1;
    end
  end

  a_int_yumi:  assert property (@(posedge clk_i) disable iff (!reset_n_i) io.int_wb_yumi_i |-> io.int_wb_v_o);
  a_fp_yumi:   assert property (@(posedge clk_i) disable iff (!reset_n_i) io.fp_wb_yumi_i  |-> io.fp_wb_v_o);
  a_ic_yumi:   assert property (@(posedge clk_i) disable iff (!reset_n_i) io.icache_yumi_i |-> io.icache_v_o);
  a_underflow: assert property (@(posedge clk_i) disable iff (!reset_n_i) (enq && !io.issue_v_i) |-> (out_cnt != '0));
  a_overflow:  assert property (@(posedge clk_i) disable iff (!reset_n_i) (io.issue_v_i && !enq) |-> (out_cnt != max_cnt_lp));
endmodule
